core_mem_arbiter: RTL

//  Shares the core's single memory bus port between instruction fetch and the data side of core_control.

---
 rtl/core_mem_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory bus port between instruction fetch and the data side.
// Define CORE_MEM_ARB_RR_EN for round-robin on contention; otherwise data has fixed priority.
module core_mem_arbiter #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insn_start,
  input  logic [ADDR_W-1:0] insn_addr,
  output logic              insn_ready,
  output logic [31:0]       insn_data,
  input  logic              data_start,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wr,
  input  logic [3:0]        data_be,
  output logic              data_ready,
  output logic [31:0]       data_rd,
  output logic              bus_start,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_data_wr,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
  input  logic [31:0]       bus_data_rd
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state;
  logic insn_pend, data_pend, owner_data, last_data, done;
  logic [ADDR_W-1:0] insn_a, data_a;
  logic data_w;
  logic [31:0] data_wd;
  logic [3:0] data_b;
  logic insn_take, data_take, pick_data, complete, fin;
  // A requester may re-request in the same cycle its ready pulse is out.
  assign insn_take = insn_start && (!insn_pend || insn_ready);
  assign data_take = data_start && (!data_pend || data_ready);
`ifdef CORE_MEM_ARB_RR_EN
  assign pick_data = data_pend && (!insn_pend || !last_data);
`else
  assign pick_data = data_pend;
`endif
  assign complete = (state == ISSUE || state == BUSY) && !done && bus_ready;
  assign fin = state == BUSY && done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      insn_pend   <= 1'b0;
      data_pend   <= 1'b0;
      owner_data  <= 1'b0;
      last_data   <= 1'b1;
      done        <= 1'b0;
      insn_a      <= '0;
      data_a      <= '0;
      data_w      <= 1'b0;
      data_wd     <= '0;
      data_b      <= '0;
      insn_ready  <= 1'b0;
      insn_data   <= '0;
      data_ready  <= 1'b0;
      data_rd     <= '0;
      bus_start   <= 1'b0;
      bus_write   <= 1'b0;
      bus_addr    <= '0;
      bus_data_wr <= '0;
      bus_be      <= '0;
    end else begin
      insn_ready <= 1'b0;
      data_ready <= 1'b0;
      bus_start  <= 1'b0;
      insn_pend  <= insn_take || (insn_pend && !(fin && !owner_data));
      data_pend  <= data_take || (data_pend && !(fin && owner_data));
      if (insn_take) insn_a <= insn_addr;
      if (data_take) begin
        data_a  <= data_addr;
        data_w  <= data_write;
        data_wd <= data_wr;
        data_b  <= data_be;
      end
      // Completion is registered; the ready pulse goes out the following cycle.
      if (complete) begin
        done       <= 1'b1;
        insn_ready <= !owner_data;
        data_ready <= owner_data;
        if (owner_data) data_rd <= bus_write ? 32'h0 : bus_data_rd;
        else insn_data <= bus_data_rd;
      end
      case (state)
        IDLE: if (insn_pend || data_pend) begin
          owner_data  <= pick_data;
          last_data   <= pick_data;
          bus_write   <= pick_data && data_w;
          bus_addr    <= pick_data ? data_a : insn_a;
          bus_data_wr <= (pick_data && data_w) ? data_wd : 32'h0;
          bus_be      <= (pick_data && data_w) ? data_b : 4'hf;
          bus_start   <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: state <= BUSY;
        BUSY: if (done) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  a_insn_proto: assert property (@(posedge clk) disable iff (rst) !(insn_start && insn_pend && !insn_ready));
  a_data_proto: assert property (@(posedge clk) disable iff (rst) !(data_start && data_pend && !data_ready));
endmodule
